// File: rtl/shifter_mc.sv
// Multi-cycle 16-bit shifter/rotator: applies the 1/2/4/8 stages one per clock.
// Optional early completion when SHIFTER_MC_SKIP_EN is defined.
module shifter_mc (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in,
    input  logic [3:0]  cnt,
    input  logic [1:0]  op,
    output logic [15:0] out,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  stg_r;
    logic [15:0] data_r;
    logic [3:0]  cnt_r;
    logic [1:0]  op_r;

    logic        accept_s;
    logic        accept_done_s;
    logic        finish_shift_s;
    logic [15:0] stage_data_s;

    // One power-of-two stage; op encoding matches the downstream shift-by-8 stage.
    function automatic logic [15:0] shift_stage(
        input logic [15:0] d,
        input logic [1:0]  o,
        input logic [1:0]  s
    );
        logic [4:0]  amt;
        logic [15:0] r;
        amt = 5'd1 << s;
        case (o)
            2'b00:   r = (d << amt) | (d >> (5'd16 - amt));
            2'b01:   r = d << amt;
            2'b10:   r = (d >> amt) | (d << (5'd16 - amt));
            2'b11:   r = d >> amt;
            default: r = d;
        endcase
        return r;
    endfunction

`ifdef SHIFTER_MC_SKIP_EN
    logic [2:0] stg_nxt_s;

    // Early exit once no count bit remains at or above the next stage.
    always_comb begin
        stg_nxt_s      = {1'b0, stg_r} + 3'd1;
        finish_shift_s = ((cnt_r >> stg_nxt_s) == 4'd0);
        accept_done_s  = (cnt == 4'd0);
    end
`else
    // Fixed latency: always walk all four stages.
    always_comb begin
        finish_shift_s = (stg_r == 2'd3);
        accept_done_s  = 1'b0;
    end
`endif

    // Request acceptance and the current stage result.
    always_comb begin
        accept_s = 1'b0;
        if ((state_r == IDLE) || (state_r == DONE)) begin
            accept_s = start;
        end else begin
            accept_s = 1'b0;
        end
        if (cnt_r[stg_r]) begin
            stage_data_s = shift_stage(data_r, op_r, stg_r);
        end else begin
            stage_data_s = data_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    next_state_s = accept_done_s ? DONE : SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (finish_shift_s) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            busy    <= (next_state_s == SHIFT);
            done    <= (next_state_s == DONE);
        end
    end

    // Datapath: operand capture, stage application, result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_r  <= 2'd0;
            data_r <= 16'd0;
            cnt_r  <= 4'd0;
            op_r   <= 2'd0;
            out    <= 16'd0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        data_r <= in;
                        cnt_r  <= cnt;
                        op_r   <= op;
                        stg_r  <= 2'd0;
                        if (accept_done_s) begin
                            out <= in;
                        end
                    end
                end
                SHIFT: begin
                    data_r <= stage_data_s;
                    stg_r  <= stg_r + 2'd1;
                    if (finish_shift_s) begin
                        out <= stage_data_s;
                    end
                end
                default: begin
                    stg_r <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifter_mc.sv
// Directed self-checking bench for shifter_mc (both latency builds).
module tb_shifter_mc;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] in_s;
    logic [3:0]  cnt_s;
    logic [1:0]  op_s;
    logic [15:0] out_s;
    logic        busy_s;
    logic        done_s;

    int checks;
    int errors;

    shifter_mc dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in_s),
        .cnt   (cnt_s),
        .op    (op_s),
        .out   (out_s),
        .busy  (busy_s),
        .done  (done_s)
    );

    always #5 clk = ~clk;

    // Edges from the accepting edge until done is seen, inclusive.
    function automatic int exp_lat(input logic [3:0] c);
`ifdef SHIFTER_MC_SKIP_EN
        if (c[3])      return 5;
        else if (c[2]) return 4;
        else if (c[1]) return 3;
        else if (c[0]) return 2;
        else           return 1;
`else
        return 5;
`endif
    endfunction

    task automatic do_op(input logic [15:0] i, input logic [3:0] c, input logic [1:0] o,
                         output logic [15:0] res, output int lat);
        @(negedge clk);
        start = 1'b1; in_s = i; cnt_s = c; op_s = o;
        @(negedge clk);
        start = 1'b0; in_s = 16'h0000; cnt_s = 4'd0; op_s = 2'd0;
        lat = 1;
        while (!done_s && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        res = out_s;
    endtask

    task automatic test_reset;
        checks++; if (out_s !== 16'h0000) begin errors++; $display("FAIL reset_out got %h exp 0000", out_s); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_s); end
    endtask

    task automatic test_rotate;
        logic [15:0] r; int l;
        do_op(16'h1234, 4'd4, 2'b00, r, l);
        checks++; if (r !== 16'h2341) begin errors++; $display("FAIL rotl4 got %h exp 2341", r); end
        checks++; if (l !== exp_lat(4'd4)) begin errors++; $display("FAIL rotl4_lat got %0d exp %0d", l, exp_lat(4'd4)); end
        do_op(16'h1234, 4'd12, 2'b10, r, l);
        checks++; if (r !== 16'h2341) begin errors++; $display("FAIL rotr12 got %h exp 2341", r); end
        checks++; if (l !== exp_lat(4'd12)) begin errors++; $display("FAIL rotr12_lat got %0d exp %0d", l, exp_lat(4'd12)); end
        do_op(16'h8001, 4'd15, 2'b00, r, l);
        checks++; if (r !== 16'hC000) begin errors++; $display("FAIL rotl15 got %h exp c000", r); end
        do_op(16'h1234, 4'd1, 2'b10, r, l);
        checks++; if (r !== 16'h091A) begin errors++; $display("FAIL rotr1 got %h exp 091a", r); end
        checks++; if (l !== exp_lat(4'd1)) begin errors++; $display("FAIL rotr1_lat got %0d exp %0d", l, exp_lat(4'd1)); end
    endtask

    task automatic test_shift;
        logic [15:0] r; int l;
        do_op(16'h00FF, 4'd8, 2'b01, r, l);
        checks++; if (r !== 16'hFF00) begin errors++; $display("FAIL shl8 got %h exp ff00", r); end
        checks++; if (l !== exp_lat(4'd8)) begin errors++; $display("FAIL shl8_lat got %0d exp %0d", l, exp_lat(4'd8)); end
        do_op(16'h8001, 4'd15, 2'b11, r, l);
        checks++; if (r !== 16'h0001) begin errors++; $display("FAIL shr15 got %h exp 0001", r); end
        do_op(16'h0001, 4'd15, 2'b01, r, l);
        checks++; if (r !== 16'h8000) begin errors++; $display("FAIL shl15 got %h exp 8000", r); end
        do_op(16'hF0F0, 4'd6, 2'b11, r, l);
        checks++; if (r !== 16'h03C3) begin errors++; $display("FAIL shr6 got %h exp 03c3", r); end
    endtask

    task automatic test_zero;
        logic [15:0] r; int l;
        for (int k = 0; k < 4; k++) begin
            do_op(16'hBEEF, 4'd0, k[1:0], r, l);
            checks++; if (r !== 16'hBEEF) begin errors++; $display("FAIL cnt0_op%0d got %h exp beef", k, r); end
            checks++; if (l !== exp_lat(4'd0)) begin errors++; $display("FAIL cnt0_lat_op%0d got %0d exp %0d", k, l, exp_lat(4'd0)); end
        end
    endtask

    task automatic test_busy;
        @(negedge clk);
        start = 1'b1; in_s = 16'h1234; cnt_s = 4'd8; op_s = 2'b00;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL busy_shift got %b exp 1", busy_s); end
        repeat (3) @(negedge clk);
        checks++; if (busy_s !== 1'b1) begin errors++; $display("FAIL busy_last got %b exp 1", busy_s); end
        @(negedge clk);
        checks++; if (busy_s !== 1'b0 || done_s !== 1'b1) begin errors++; $display("FAIL busy_done got busy=%b done=%b exp busy=0 done=1", busy_s, done_s); end
        checks++; if (out_s !== 16'h3412) begin errors++; $display("FAIL rotl8 got %h exp 3412", out_s); end
        @(negedge clk);
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done_s); end
    endtask

    task automatic test_ignore_start;
        int pulses; logic [15:0] r;
        pulses = 0; r = 16'h0000;
        @(negedge clk);
        start = 1'b1; in_s = 16'h1234; cnt_s = 4'd4; op_s = 2'b00;
        @(negedge clk);
        start = 1'b0; in_s = 16'h0000; cnt_s = 4'd0;
        @(negedge clk);
        start = 1'b1; in_s = 16'hFFFF; cnt_s = 4'd1; op_s = 2'b01;
        @(negedge clk);
        start = 1'b0; in_s = 16'h0000; cnt_s = 4'd0; op_s = 2'b00;
        for (int k = 0; k < 12; k++) begin
            if (done_s) begin pulses++; r = out_s; end
            @(negedge clk);
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL ignore_pulses got %0d exp 1", pulses); end
        checks++; if (r !== 16'h2341) begin errors++; $display("FAIL ignore_result got %h exp 2341", r); end
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL ignore_idle got %b exp 0", busy_s); end
    endtask

    task automatic test_back_to_back;
        int cyc, n, t0, t1; logic [15:0] r0, r1;
        n = 0; t0 = 0; t1 = 0; r0 = 16'h0000; r1 = 16'h0000;
        @(negedge clk);
        start = 1'b1; in_s = 16'h00FF; cnt_s = 4'd8; op_s = 2'b01;
        cyc = 0;
        while (n < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done_s) begin
                if (n == 0) begin
                    t0 = cyc; r0 = out_s;
                    in_s = 16'h0F0F; cnt_s = 4'd4; op_s = 2'b00;
                end else begin
                    t1 = cyc; r1 = out_s;
                    start = 1'b0;
                end
                n++;
            end
        end
        start = 1'b0;
        checks++; if (n !== 2) begin errors++; $display("FAIL b2b_pulses got %0d exp 2", n); end
        checks++; if (r0 !== 16'hFF00) begin errors++; $display("FAIL b2b_first got %h exp ff00", r0); end
        checks++; if (r1 !== 16'hF0F0) begin errors++; $display("FAIL b2b_second got %h exp f0f0", r1); end
        checks++; if (t1 - t0 !== exp_lat(4'd4)) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", t1 - t0, exp_lat(4'd4)); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [15:0] r; int l; int pulses;
        pulses = 0;
        @(negedge clk);
        start = 1'b1; in_s = 16'h1234; cnt_s = 4'd15; op_s = 2'b00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy_s); end
        checks++; if (done_s !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b exp 0", done_s); end
        checks++; if (out_s !== 16'h0000) begin errors++; $display("FAIL rstmid_out got %h exp 0000", out_s); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_s) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_nodone got %0d exp 0", pulses); end
        do_op(16'h00FF, 4'd8, 2'b01, r, l);
        checks++; if (r !== 16'hFF00) begin errors++; $display("FAIL rstmid_after got %h exp ff00", r); end
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst = 1'b1; start = 1'b0;
        in_s = 16'h0000; cnt_s = 4'd0; op_s = 2'b00;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        test_rotate;
        test_shift;
        test_zero;
        test_busy;
        test_ignore_start;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
